// File: rtl/rates_shaper_pkg.sv
// Shared widths, FSM state type and beat helpers for the rates token-bucket shaper.
package rates_shaper_pkg;

    localparam int unsigned DATA_WIDTH_IN_BYTES = 16;
    localparam int unsigned FRAC_W              = 8;
    localparam int unsigned TOKEN_W             = 24;
    localparam int unsigned RATE_W              = 16;
    localparam int unsigned DATA_W              = 8 * DATA_WIDTH_IN_BYTES;
    localparam int unsigned EMPTY_W             = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int unsigned BYTES_W             = $clog2(DATA_WIDTH_IN_BYTES) + 1;
    localparam int unsigned BKT_W               = TOKEN_W + FRAC_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } shaper_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    // Valid bytes carried by a beat; empty only counts on the last beat.
    function automatic logic [BYTES_W-1:0] beat_bytes(input logic eop, input logic [EMPTY_W-1:0] empty);
        beat_bytes = eop ? (BYTES_W'(DATA_WIDTH_IN_BYTES) - BYTES_W'(empty))
                         : BYTES_W'(DATA_WIDTH_IN_BYTES);
    endfunction

endpackage

// File: rtl/rates_shaper_token_bucket.sv
// Signed saturating token bucket in Q(TOKEN_W).FRAC_W bytes; may run into deficit.
module rates_token_bucket
    import rates_shaper_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [RATE_W-1:0]         rate,
    input  logic [TOKEN_W-1:0]        burst,
    input  logic                      consume,
    input  logic [BYTES_W-1:0]        consume_bytes,
    output logic signed [TOKEN_W:0]   tokens,
    output logic                      gate_ok
);

    localparam int unsigned SUM_W = BKT_W + 2;
    localparam logic signed [SUM_W-1:0] FLOOR = {{(SUM_W-BKT_W+1){1'b1}}, {(BKT_W-1){1'b0}}};

    logic signed [BKT_W-1:0] r_bucket;
    logic signed [SUM_W-1:0] w_cur;
    logic signed [SUM_W-1:0] w_add;
    logic signed [SUM_W-1:0] w_sub;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_ceil;
    logic signed [SUM_W-1:0] w_clamped;

    assign w_cur  = {{(SUM_W-BKT_W){r_bucket[BKT_W-1]}}, r_bucket};
    assign w_add  = {{(SUM_W-RATE_W){1'b0}}, rate};
    assign w_sub  = consume ? {{(SUM_W-BYTES_W-FRAC_W){1'b0}}, consume_bytes, {FRAC_W{1'b0}}} : '0;
    assign w_ceil = {{(SUM_W-TOKEN_W-FRAC_W){1'b0}}, burst, {FRAC_W{1'b0}}};
    assign w_sum  = w_cur + w_add - w_sub;

    // Credit and debit land together; clamp to the ceiling, saturate at the floor.
    always_comb begin
        w_clamped = w_sum;
        if (w_sum > w_ceil) begin
            w_clamped = w_ceil;
        end else if (w_sum < FLOOR) begin
            w_clamped = FLOOR;
        end
    end

    // Bucket register; held full while shaping is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bucket <= '0;
        end else if (!enable) begin
            r_bucket <= w_ceil[BKT_W-1:0];
        end else begin
            r_bucket <= w_clamped[BKT_W-1:0];
        end
    end

    assign tokens  = r_bucket[BKT_W-1:FRAC_W];
    assign gate_ok = ~r_bucket[BKT_W-1];

endmodule

// File: rtl/rates_shaper.sv
// Token-bucket shaper releasing whole messages when byte credit allows.
// Optional statistics counters: define RATES_SHAPER_STATS_EN.
module rates_shaper
    import rates_shaper_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_enable,
    input  logic [RATE_W-1:0]         cfg_rate,
    input  logic [TOKEN_W-1:0]        cfg_burst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [EMPTY_W-1:0]        in_empty,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [EMPTY_W-1:0]        out_empty,
    output logic signed [TOKEN_W:0]   tokens
`ifdef RATES_SHAPER_STATS_EN
    ,
    output logic [31:0]               stat_msgs,
    output logic [47:0]               stat_bytes,
    output logic [31:0]               stat_gated
`endif
);

    shaper_state_e      r_state;
    shaper_state_e      w_state_next;
    beat_t              r_out;
    logic               r_out_valid;
    logic               w_slot_free;
    logic               w_bucket_ok;
    logic               w_gate;
    logic               w_in_ready;
    logic               w_accept;
    logic [BYTES_W-1:0] w_bytes;

    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_gate      = cfg_enable ? w_bucket_ok : 1'b1;
    assign w_accept    = in_valid & w_in_ready;
    assign w_bytes     = beat_bytes(in_eop, in_empty);

    rates_token_bucket u_bucket (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (cfg_enable),
        .rate          (cfg_rate),
        .burst         (cfg_burst),
        .consume       (w_accept),
        .consume_bytes (w_bytes),
        .tokens        (tokens),
        .gate_ok       (w_bucket_ok)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: track message boundaries on accepted beats.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && in_sop && !in_eop) w_state_next = PASS;
            PASS:    if (w_accept && in_eop)            w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM output: only message starts are gated by credit; held low in reset.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = w_gate & w_slot_free;
            PASS:    w_in_ready = w_slot_free;
            default: w_in_ready = 1'b0;
        endcase
        w_in_ready = w_in_ready & rst_n;
    end

    assign in_ready = w_in_ready;

    // Single output register stage; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_slot_free) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out.data;
    assign out_sop   = r_out.sop;
    assign out_eop   = r_out.eop;
    assign out_empty = r_out.empty;

`ifdef RATES_SHAPER_STATS_EN
    logic [31:0] r_stat_msgs;
    logic [47:0] r_stat_bytes;
    logic [31:0] r_stat_gated;

    // Wrapping traffic counters: messages, bytes, and credit-gated start cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_msgs  <= '0;
            r_stat_bytes <= '0;
            r_stat_gated <= '0;
        end else begin
            if (w_accept && in_eop) r_stat_msgs <= r_stat_msgs + 32'd1;
            if (w_accept)           r_stat_bytes <= r_stat_bytes + 48'(w_bytes);
            if ((r_state == IDLE) && in_valid && in_sop && !w_gate) r_stat_gated <= r_stat_gated + 32'd1;
        end
    end

    assign stat_msgs  = r_stat_msgs;
    assign stat_bytes = r_stat_bytes;
    assign stat_gated = r_stat_gated;
`endif

endmodule

// File: tb/tb_rates_shaper.sv
// Directed bench for rates_shaper: per-cycle vector table plus multi-cycle sequences.
module tb_rates_shaper;
    import rates_shaper_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_enable;
    logic [RATE_W-1:0]       cfg_rate;
    logic [TOKEN_W-1:0]      cfg_burst;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_sop;
    logic                    in_eop;
    logic [EMPTY_W-1:0]      in_empty;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_sop;
    logic                    out_eop;
    logic [EMPTY_W-1:0]      out_empty;
    logic signed [TOKEN_W:0] tokens;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rates_shaper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_enable (cfg_enable),
        .cfg_rate   (cfg_rate),
        .cfg_burst  (cfg_burst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .tokens     (tokens)
    );

    typedef struct {
        logic        en;
        logic [23:0] burst;
        logic        vld;
        logic        sop;
        logic        eop;
        logic [3:0]  emp;
        logic [31:0] tag;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_tag;
        int          e_tok;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [23:0] burst, input logic vld,
                                input logic sop, input logic eop, input logic [3:0] emp,
                                input logic [31:0] tag, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [31:0] e_tag, input int e_tok);
        vec_t v;
        v.en = en; v.burst = burst; v.vld = vld; v.sop = sop; v.eop = eop; v.emp = emp;
        v.tag = tag; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_tag = e_tag; v.e_tok = e_tok;
        return v;
    endfunction

    // Send one message of nbytes as back-to-back beats; counts cycles with in_ready low.
    task automatic send_msg(input int nbytes, input int base_tag, output int stalls);
        int beats;
        int k;
        int last_bytes;
        logic acc;
        beats  = (nbytes + 15) / 16;
        last_bytes = nbytes - 16 * (beats - 1);
        k      = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 2000 && k < beats; cyc++) begin
            in_valid = 1'b1;
            in_sop   = (k == 0);
            in_eop   = (k == beats - 1);
            in_empty = (k == beats - 1) ? 4'(16 - last_bytes) : 4'd0;
            in_data  = {4{32'(base_tag + k)}};
            #1;
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        if (k != beats) begin
            failures++;
            $display("FAIL send_msg_timeout actual=%0d required=%0d", k, beats);
        end
    endtask

    initial begin
        int stalls;
        int total;
        int gated;
        int errs;
        int bytes;
        int beat;
        logic acc;

        // Per-cycle vectors: rate fixed at 4 B/cycle, bucket starts at 0.
        vecs[0]  = mk(1, 20, 0, 0, 0, 0,  32'h0,  1, 1, 0, 32'h0,  4);
        vecs[1]  = mk(1, 20, 1, 1, 1, 6,  32'hA1, 1, 1, 1, 32'hA1, -2);
        vecs[2]  = mk(1, 20, 1, 1, 1, 0,  32'hB2, 1, 0, 0, 32'h0,  2);
        vecs[3]  = mk(1, 20, 1, 1, 1, 0,  32'hB2, 1, 1, 1, 32'hB2, -10);
        vecs[4]  = mk(1, 20, 1, 1, 0, 0,  32'hC3, 1, 0, 0, 32'h0,  -6);
        vecs[5]  = mk(1, 20, 1, 1, 0, 0,  32'hC3, 1, 0, 0, 32'h0,  -2);
        vecs[6]  = mk(1, 20, 1, 1, 0, 0,  32'hC3, 1, 0, 0, 32'h0,  2);
        vecs[7]  = mk(1, 20, 1, 1, 0, 0,  32'hC3, 1, 1, 1, 32'hC3, -10);
        vecs[8]  = mk(1, 20, 1, 0, 0, 0,  32'hD4, 1, 1, 1, 32'hD4, -22);
        vecs[9]  = mk(1, 20, 1, 0, 1, 15, 32'hE5, 1, 1, 1, 32'hE5, -19);
        vecs[10] = mk(1, 20, 0, 0, 0, 0,  32'h0,  1, 0, 0, 32'h0,  -15);
        vecs[11] = mk(0, 20, 0, 0, 0, 0,  32'h0,  1, 1, 0, 32'h0,  20);
        vecs[12] = mk(1, 20, 0, 0, 0, 0,  32'h0,  1, 1, 0, 32'h0,  20);
        vecs[13] = mk(1, 8,  0, 0, 0, 0,  32'h0,  1, 1, 0, 32'h0,  8);
        vecs[14] = mk(1, 8,  1, 1, 1, 0,  32'hF6, 0, 1, 1, 32'hF6, -4);
        vecs[15] = mk(1, 8,  1, 1, 1, 0,  32'h77, 0, 0, 1, 32'hF6, 0);
        vecs[16] = mk(1, 8,  1, 1, 1, 0,  32'h77, 0, 0, 1, 32'hF6, 4);
        vecs[17] = mk(1, 8,  1, 1, 1, 0,  32'h77, 1, 1, 1, 32'h77, -8);
        vecs[18] = mk(1, 8,  0, 0, 0, 0,  32'h0,  1, 0, 0, 32'h0,  -4);
        vecs[19] = mk(1, 8,  1, 0, 0, 0,  32'h88, 1, 0, 0, 32'h0,  0);
        vecs[20] = mk(1, 8,  1, 0, 0, 0,  32'h88, 1, 1, 1, 32'h88, -12);
        vecs[21] = mk(1, 8,  1, 1, 1, 0,  32'h99, 1, 0, 0, 32'h0,  -8);
        vecs[22] = mk(1, 8,  0, 0, 0, 0,  32'h0,  1, 0, 0, 32'h0,  -4);
        vecs[23] = mk(0, 8,  1, 1, 1, 0,  32'h5A, 1, 1, 1, 32'h5A, 8);
        vecs[24] = mk(0, 8,  1, 1, 1, 0,  32'h6B, 1, 1, 1, 32'h6B, 8);

        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        cfg_rate   = 16'h0400;
        cfg_burst  = 24'd20;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_empty   = '0;
        in_data    = '0;
        out_ready  = 1'b1;

        #2;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_tokens", longint'(tokens), 0);
        chk("reset_in_ready", longint'(in_ready), 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: drive a cycle, check in_ready before the edge, outputs after it.
        for (int i = 0; i < NVEC; i++) begin
            cfg_enable = vecs[i].en;
            cfg_burst  = vecs[i].burst;
            in_valid   = vecs[i].vld;
            in_sop     = vecs[i].sop;
            in_eop     = vecs[i].eop;
            in_empty   = vecs[i].emp;
            in_data    = {4{vecs[i].tag}};
            out_ready  = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), longint'(in_ready), longint'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), longint'(out_valid), longint'(vecs[i].e_ov));
            chk($sformatf("v%0d_tokens", i), longint'(tokens), longint'(vecs[i].e_tok));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_data_lo", i), longint'(out_data[31:0]), longint'(vecs[i].e_tag));
                chk($sformatf("v%0d_data_hi", i), longint'(out_data[127:96]), longint'(vecs[i].e_tag));
                chk($sformatf("v%0d_sop", i), longint'(out_sop), longint'(vecs[i].sop));
                chk($sformatf("v%0d_eop", i), longint'(out_eop), longint'(vecs[i].eop));
                chk($sformatf("v%0d_empty", i), longint'(out_empty), longint'(vecs[i].emp));
            end
        end

        // Asynchronous reset in the middle of traffic.
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", longint'(out_valid), 0);
        chk("async_rst_tokens", longint'(tokens), 0);
        chk("async_rst_in_ready", longint'(in_ready), 0);
        in_valid   = 1'b0;
        cfg_enable = 1'b1;
        cfg_rate   = 16'h0400;
        cfg_burst  = 24'd256;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Deficit: 1000B message from an empty bucket passes without stalls.
        send_msg(1000, 0, stalls);
        chk("deficit_stalls", longint'(stalls), 0);
        chk("deficit_tokens", longint'(tokens), -748);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        in_empty = '0;
        gated    = 0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (in_ready) break;
            gated++;
            @(posedge clk);
            #1;
        end
        chk("deficit_gated_cycles", longint'(gated), 187);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Burst cap: long idle fills to the ceiling, then four 64B messages flow.
        repeat (100) @(posedge clk);
        #1;
        chk("burst_cap_tokens", longint'(tokens), 256);
        total = 0;
        for (int m = 0; m < 4; m++) begin
            send_msg(64, 100 * m, stalls);
            total += stalls;
        end
        chk("burst_stalls", longint'(total), 0);
        chk("burst_tokens_after", longint'(tokens), 64);

        // Long-run rate with saturating 64B messages.
        bytes = 0;
        beat  = 0;
        for (int c = 0; c < 4000; c++) begin
            in_valid = 1'b1;
            in_sop   = (beat == 0);
            in_eop   = (beat == 3);
            in_empty = '0;
            in_data  = {4{32'(beat)}};
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bytes += 16;
                beat = (beat + 1) % 4;
            end
        end
        chk_range("rate_bytes_4000cyc", longint'(bytes), 15840, 16160);

        // Drain any partial message so the next test starts at a boundary.
        for (int c = 0; c < 500 && beat != 0; c++) begin
            in_sop = 1'b0;
            in_eop = (beat == 3);
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) beat = (beat + 1) % 4;
        end
        chk("rate_drain_done", longint'(beat), 0);

        // Transparent mode: one beat per cycle, in order, latency 1.
        cfg_enable = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk);
        #1;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'b1;
            in_sop   = (i % 4 == 0);
            in_eop   = (i % 4 == 3);
            in_empty = '0;
            in_data  = {4{32'(i + 1000)}};
            #1;
            if (!in_ready) errs++;
            @(posedge clk);
            #1;
            if (!out_valid || out_data[31:0] != 32'(i + 1000)) errs++;
        end
        in_valid = 1'b0;
        chk("transparent_errors", longint'(errs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
